regfile_write_arbiter: RTL

Shares the register file's single write port between two writeback requesters: req0 (ALU writeback) and req1 (load writeback). Arbitration is round-robin with a valid/ready handshake. The winner is registered into one output stage, which drives write address, data, an aggregate write enable and a one-hot per-register write-enable vector into the bit-level write-enabled register cells. Writes to the hardwired zero register are absorbed and never reach the array. A saturating counter records write-port contention.

---
 rtl/regfile_write_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Two writeback requesters (req0 = ALU, req1 = load) share one write port
// through a round-robin valid/ready handshake. The winning request is
// registered into a single output stage that drives the write index, data,
// aggregate enable and one-hot per-register enable. Writes aimed at the
// hardwired zero register are accepted but never enable a cell. A saturating
// counter tracks cycles in which both requesters competed for the port.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      req0_valid,
    input  logic [ADDR_WIDTH-1:0]     req0_addr,
    input  logic [DATA_WIDTH-1:0]     req0_data,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [ADDR_WIDTH-1:0]     req1_addr,
    input  logic [DATA_WIDTH-1:0]     req1_data,
    output logic                      req1_ready,
    output logic                      wr_en,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [2**ADDR_WIDTH-1:0]  wr_dec,
    output logic [CNT_WIDTH-1:0]      contention_cnt
);

    localparam int                    NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

    // Round-robin pointer: 0 favours req0, 1 favours req1 on a tie.
    logic                   ptr;

    logic                   grant;
    logic                   grant_we;
    logic                   contend;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [NUM_REGS-1:0]    dec_next;

    // Handshake: a lone requester always wins; on a tie the pointer decides.
    // Readies are also held low while reset is asserted so nothing is
    // accepted into a stage that is being cleared.
    always_comb begin
        req0_ready = reset && !stall && req0_valid && (!req1_valid || !ptr);
        req1_ready = reset && !stall && req1_valid && (!req0_valid ||  ptr);
    end

    // Select the winner's payload and decode its one-hot cell enable.
    always_comb begin
        // NOTE: every signal gets a default before any conditional update so
        // no path leaves it unassigned, which would otherwise infer a latch.
        sel_addr = req0_addr;
        sel_data = req0_data;
        dec_next = '0;
        if (req1_ready) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
        end
        grant    = req0_ready || req1_ready;
        // The zero register completes its handshake but never writes a cell.
        grant_we = grant && (sel_addr != ZERO_IDX);
        if (grant_we) begin
            dec_next[sel_addr] = 1'b1;
        end
        contend  = req0_valid && req1_valid && !stall;
    end

    // Pointer flips away from whichever requester just transferred.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            ptr <= 1'b0;
        end else if (req0_ready) begin
            ptr <= 1'b1;
        end else if (req1_ready) begin
            ptr <= 1'b0;
        end
    end

    // Output stage: enables pulse for one cycle per accepted write; index and
    // data hold their last value when nothing was accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_dec  <= '0;
        end else begin
            wr_en  <= grant_we;
            wr_dec <= dec_next;
            if (grant) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    // Contention counter saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            contention_cnt <= '0;
        end else if (contend && (contention_cnt != CNT_MAX)) begin
            contention_cnt <= contention_cnt + 1'b1;
        end
    end

endmodule
